// File: rtl/piso_buffer.sv
// Parallel-input, single-output buffer: LENGTH producers post words into private slots,
// drained one per load through a registered valid/ack output. Macro PISO_BUFFER_RR_EN selects round-robin drain.
`timescale 1ns/1ps

module piso_buffer #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  d_in [LENGTH-1:0],
  input  logic [LENGTH-1:0] we,
  output logic [LENGTH-1:0] used_pos,
  output logic [WIDTH-1:0]  d_out,
  output logic              d_out_valid,
  input  logic              d_out_ack,
  output logic              ovf,
  output logic              empty
);

  localparam int SEL_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  typedef logic [SEL_W-1:0] sel_t;

  logic [WIDTH-1:0]  slot_data [LENGTH];
  sel_t              last_sel;
  sel_t              sel_idx;
  logic              sel_found;
  logic              load;
  logic              drain;
  logic [LENGTH-1:0] drain_mask;
  logic [LENGTH-1:0] wr_accept;
  logic [LENGTH-1:0] wr_drop;
  logic [LENGTH-1:0] used_next;

  // The output register may take a new word when it is empty or being accepted this cycle.
  assign load  = !d_out_valid || d_out_ack;
  assign drain = load && sel_found;
  assign empty = (used_pos == '0) && !d_out_valid;

`ifdef PISO_BUFFER_RR_EN
  // Search begins just past the last slot drained, so every producer gets a turn.
  always_comb begin
    sel_t cand;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    sel_idx   = last_sel;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= LENGTH; k++) begin
      cand = sel_t'((int'(last_sel) + k) % LENGTH);
      if (!sel_found && used_pos[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end
`else
  // Fixed priority: scanning downward lets the lowest used index overwrite any higher one.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = LENGTH - 1; i >= 0; i--) begin
      if (used_pos[i]) begin
        sel_found = 1'b1;
        sel_idx   = sel_t'(i);
      end
    end
  end

  logic unused_last_sel;
  assign unused_last_sel = ^last_sel;
`endif

  // A write lands if its slot is free before the edge or is the one being drained on it.
  always_comb begin
    drain_mask = '0;
    wr_accept  = '0;
    wr_drop    = '0;
    used_next  = used_pos;
    if (drain) drain_mask[sel_idx] = 1'b1;
    for (int i = 0; i < LENGTH; i++) begin
      wr_accept[i] = we[i] && (!used_pos[i] || drain_mask[i]);
      wr_drop[i]   = we[i] && !wr_accept[i];
      used_next[i] = wr_accept[i] || (used_pos[i] && !drain_mask[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      used_pos    <= '0;
      d_out       <= '0;
      d_out_valid <= 1'b0;
      ovf         <= 1'b0;
      last_sel    <= sel_t'(LENGTH - 1);
    end else begin
      used_pos <= used_next;
      if (load) begin
        if (sel_found) begin
          d_out       <= slot_data[sel_idx];
          d_out_valid <= 1'b1;
          last_sel    <= sel_idx;
        end else begin
          d_out_valid <= 1'b0;
        end
      end
      if (wr_drop != '0) ovf <= 1'b1;
    end
  end

  // NOTE: slot storage is reset explicitly because buffered words must read back as zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LENGTH; i++) slot_data[i] <= '0;
    end else begin
      for (int i = 0; i < LENGTH; i++) begin
        if (wr_accept[i]) slot_data[i] <= d_in[i];
      end
    end
  end

endmodule

// File: tb/tb_piso_buffer.sv
// Self-checking bench for piso_buffer (WIDTH=8, LENGTH=4): expected words are queued as stimulus is
// driven and popped as the DUT delivers them; inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_piso_buffer;
  localparam int WIDTH  = 8;
  localparam int LENGTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WIDTH-1:0]  d_in [LENGTH-1:0];
  logic [LENGTH-1:0] we = '0;
  logic [LENGTH-1:0] used_pos;
  logic [WIDTH-1:0]  d_out;
  logic              d_out_valid;
  logic              d_out_ack = 1'b0;
  logic              ovf;
  logic              empty;

  logic [WIDTH-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_buffer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .we          (we),
    .used_pos    (used_pos),
    .d_out       (d_out),
    .d_out_valid (d_out_valid),
    .d_out_ack   (d_out_ack),
    .ovf         (ovf),
    .empty       (empty)
  );

  // One rising edge; write enables last exactly one cycle.
  task automatic tick();
    @(negedge clk);
    we = '0;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    we        = '0;
    d_out_ack = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < LENGTH; i++) d_in[i] = '0;
    @(negedge clk);
    checks++;
    if ({used_pos, d_out, d_out_valid, ovf, empty} !== {4'b0000, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_initial got used=%b d_out=%h v=%b ovf=%b empty=%b exp 0000/00/0/0/1",
               used_pos, d_out, d_out_valid, ovf, empty);
    end
    rst = 1'b1;
    d_in[0] = 8'h11; we = 4'b0001; tick();
    checks++;
    if ({used_pos, d_out_valid} !== {4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL reset_fill got used=%b v=%b exp used=0001 v=0", used_pos, d_out_valid);
    end
    d_in[0] = 8'h12; we = 4'b0001; tick();
    checks++;
    if ({d_out, d_out_valid, used_pos, ovf} !== {8'h11, 1'b1, 4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL reset_load got d_out=%h v=%b used=%b ovf=%b exp 11/1/0001/0",
               d_out, d_out_valid, used_pos, ovf);
    end
    d_in[0] = 8'h13; we = 4'b0001; tick();
    checks++;
    if ({ovf, d_out} !== {1'b1, 8'h11}) begin
      failures++;
      $display("FAIL reset_pre_ovf got ovf=%b d_out=%h exp ovf=1 d_out=11", ovf, d_out);
    end
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({used_pos, d_out, d_out_valid, ovf, empty} !== {4'b0000, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_async got used=%b d_out=%h v=%b ovf=%b empty=%b exp 0000/00/0/0/1",
               used_pos, d_out, d_out_valid, ovf, empty);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    logic [WIDTH-1:0] exp_w;
    apply_reset();
    d_in[2] = 8'hA5; we = 4'b0100; exp_q.push_back(8'hA5);
    tick();
    checks++;
    if ({used_pos, d_out_valid} !== {4'b0100, 1'b0}) begin
      failures++;
      $display("FAIL single_slot got used=%b v=%b exp used=0100 v=0", used_pos, d_out_valid);
    end
    tick();
    checks++;
    if ({d_out_valid, used_pos} !== {1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL single_valid got v=%b used=%b exp v=1 used=0000", d_out_valid, used_pos);
    end
    exp_w = exp_q.pop_front();
    checks++;
    if (d_out !== exp_w) begin
      failures++;
      $display("FAIL single_data got %h exp %h", d_out, exp_w);
    end
    d_out_ack = 1'b1;
    tick();
    d_out_ack = 1'b0;
    checks++;
    if ({d_out_valid, empty} !== {1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_drained got v=%b empty=%b exp v=0 empty=1", d_out_valid, empty);
    end
  endtask

  task automatic test_arbitration();
    logic [WIDTH-1:0] exp_w;
    int got = 0;
    apply_reset();
    d_in[0] = 8'h11; d_in[1] = 8'h22; d_in[2] = 8'h33; d_in[3] = 8'h44;
    we = 4'b1111; d_out_ack = 1'b1;
`ifdef PISO_BUFFER_RR_EN
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
`else
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h55);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
`endif
    tick();
    checks++;
    if (used_pos !== 4'b1111) begin
      failures++;
      $display("FAIL arb_fill got used=%b exp 1111", used_pos);
    end
    tick();
    // Slot 0 has just been drained, so the late word is accepted into it.
    d_in[0] = 8'h55; we = 4'b0001;
    for (int c = 0; c < 12 && got < 5; c++) begin
      if (d_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL arb_extra got unexpected word %h", d_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (d_out !== exp_w) begin
            failures++;
            $display("FAIL arb_order word %0d got %h exp %h", got, d_out, exp_w);
          end
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got !== 5 || empty !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL arb_done got words=%0d empty=%b ovf=%b exp words=5 empty=1 ovf=0", got, empty, ovf);
    end
    d_out_ack = 1'b0;
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp_w;
    int got = 0;
    apply_reset();
    d_in[0] = 8'h5A; d_in[1] = 8'h66; we = 4'b0011;
    exp_q.push_back(8'h5A); exp_q.push_back(8'h66);
    tick();
    tick();
    checks++;
    if ({d_out, d_out_valid, used_pos, ovf} !== {8'h5A, 1'b1, 4'b0010, 1'b0}) begin
      failures++;
      $display("FAIL ovf_setup got d_out=%h v=%b used=%b ovf=%b exp 5a/1/0010/0",
               d_out, d_out_valid, used_pos, ovf);
    end
    d_in[1] = 8'h77; we = 4'b0010;
    tick();
    checks++;
    if ({ovf, used_pos, d_out} !== {1'b1, 4'b0010, 8'h5A}) begin
      failures++;
      $display("FAIL ovf_set got ovf=%b used=%b d_out=%h exp 1/0010/5a", ovf, used_pos, d_out);
    end
    d_out_ack = 1'b1;
    for (int c = 0; c < 8 && got < 2; c++) begin
      if (d_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL ovf_extra got unexpected word %h", d_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (d_out !== exp_w) begin
            failures++;
            $display("FAIL ovf_data word %0d got %h exp %h", got, d_out, exp_w);
          end
        end
        got++;
      end
      tick();
    end
    tick();
    tick();
    checks++;
    if (got !== 2 || d_out_valid !== 1'b0 || empty !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got words=%0d v=%b empty=%b ovf=%b exp words=2 v=0 empty=1 ovf=1",
               got, d_out_valid, empty, ovf);
    end
    d_out_ack = 1'b0;
  endtask

  task automatic test_rewrite_on_drain();
    logic [WIDTH-1:0] exp_w;
    int got = 0;
    apply_reset();
    d_in[3] = 8'h88; we = 4'b1000; exp_q.push_back(8'h88);
    tick();
    checks++;
    if ({used_pos, d_out_valid} !== {4'b1000, 1'b0}) begin
      failures++;
      $display("FAIL rewrite_setup got used=%b v=%b exp used=1000 v=0", used_pos, d_out_valid);
    end
    d_in[3] = 8'h99; we = 4'b1000; exp_q.push_back(8'h99);
    tick();
    checks++;
    if ({d_out, d_out_valid, used_pos, ovf} !== {8'h88, 1'b1, 4'b1000, 1'b0}) begin
      failures++;
      $display("FAIL rewrite_same_edge got d_out=%h v=%b used=%b ovf=%b exp 88/1/1000/0",
               d_out, d_out_valid, used_pos, ovf);
    end
    d_out_ack = 1'b1;
    for (int c = 0; c < 8 && got < 2; c++) begin
      if (d_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rewrite_extra got unexpected word %h", d_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (d_out !== exp_w) begin
            failures++;
            $display("FAIL rewrite_data word %0d got %h exp %h", got, d_out, exp_w);
          end
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got !== 2 || empty !== 1'b1) begin
      failures++;
      $display("FAIL rewrite_done got words=%0d empty=%b exp words=2 empty=1", got, empty);
    end
    d_out_ack = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] exp_w;
    apply_reset();
    d_in[0] = 8'hA1; d_in[1] = 8'hA2; d_in[2] = 8'hA3; d_in[3] = 8'hA4;
    we = 4'b1111;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({d_out, d_out_valid, used_pos} !== {8'hA1, 1'b1, 4'b1110}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got d_out=%h v=%b used=%b exp a1/1/1110",
                 c, d_out, d_out_valid, used_pos);
      end
      tick();
    end
    // With ack held, every cycle must present a fresh word.
    d_out_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (!d_out_valid || exp_q.size() == 0) begin
        failures++;
        $display("FAIL bp_stream cycle %0d got v=%b queued=%0d exp v=1", c, d_out_valid, exp_q.size());
      end else begin
        exp_w = exp_q.pop_front();
        if (d_out !== exp_w) begin
          failures++;
          $display("FAIL bp_data cycle %0d got %h exp %h", c, d_out, exp_w);
        end
      end
      tick();
    end
    checks++;
    if ({empty, ovf} !== {1'b1, 1'b0} || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_done got empty=%b ovf=%b queued=%0d exp empty=1 ovf=0 queued=0",
               empty, ovf, exp_q.size());
    end
    d_out_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_overflow();
    test_rewrite_on_drain();
    test_back_pressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_buffer.md
Name: piso_buffer

Overview:
- Parallel-input, single-output buffer: the drain-side counterpart of the single-input parallel-output buffer.
- LENGTH producers each own one slot and can deposit a word in the same cycle.
- The block drains the occupied slots one at a time through a registered output with a valid/ack handshake.
- Used where several units (e.g. execution ports) post results to one shared consumer such as a writeback bus.

Parameters:
- WIDTH, 32, data word width in bits.
- LENGTH, 4, number of slots / producers (>= 2).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- d_in  in  WIDTH x LENGTH (unpacked array [LENGTH-1:0])  per-slot write data.
- we  in  LENGTH  per-slot write enable.
- used_pos  out  LENGTH  slot-occupied flags.
- d_out  out  WIDTH  output word (registered).
- d_out_valid  out  1  d_out holds an undelivered word.
- d_out_ack  in  1  consumer accepts d_out this cycle; ignored when d_out_valid=0.
- ovf  out  1  sticky: a write was dropped.
- empty  out  1  combinational: used_pos==0 and d_out_valid==0.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed), held while low:
  - all slot data = 0, used_pos = 0.
  - d_out = 0, d_out_valid = 0, ovf = 0.
  - round-robin pointer last_sel = LENGTH-1.
  - Reset mid-operation discards all buffered and output words.
- load = !d_out_valid || d_out_ack, evaluated each cycle.
- load=1 with at least one used slot:
  - select slot s (see Optional Feature).
  - posedge: d_out <= data[s], d_out_valid <= 1, used_pos[s] <= 0, last_sel <= s.
- load=1 with no used slot: d_out_valid <= 0, d_out holds its last value.
- load=0: output register, used_pos and last_sel unchanged by the drain logic.
- Write, for each i with we[i]=1:
  - slot free, or slot i drained this same edge: data[i] <= d_in[i], used_pos[i] <= 1.
  - otherwise the write is dropped, slot contents are untouched, and ovf <= 1.
- ovf clears only on reset.
- No bypass: a word written at edge N is selectable at edge N+1 at the earliest.
  - Minimum latency is we high in cycle k, d_out_valid high after edge k+1.
- Throughput is one word per cycle while d_out_ack is held high and slots are non-empty.
- Selection considers only used_pos as registered before the edge; same-edge writes never win.
- Simultaneous writes to all LENGTH slots are legal.

Optional Feature:
- Macro PISO_BUFFER_RR_EN.
- Defined: round-robin selection.
  - Search starts at (last_sel+1) mod LENGTH and wraps; the first used slot wins.
  - last_sel updates only on a load that selects a slot.
- Undefined: fixed priority; lowest-index used slot wins.
  - last_sel register is still present but unused by selection.

Test Plan (WIDTH=8, LENGTH=4):
- Reset with buffered data:
  - stimulus: write 8'h11 to slot 0, then drop rst between clock edges.
  - response: immediately used_pos=4'b0000, d_out=8'h00, d_out_valid=0, ovf=0, empty=1.
- Single write:
  - stimulus: we=4'b0100, d_in[2]=8'hA5 in cycle 0, d_out_ack=0.
  - response: after edge 0 used_pos=4'b0100; after edge 1 d_out=8'hA5, d_out_valid=1, used_pos=4'b0000.
  - then: ack for one cycle; d_out_valid=0 and empty=1 after that edge.
- Arbitration order:
  - stimulus: cycle 0 write slots 0-3 with 11,22,33,44; ack held 1; cycle 1 write slot 0 with 55.
  - response with PISO_BUFFER_RR_EN: d_out sequence 11,22,33,44,55.
  - response without it: 11,22,55,33,44.
- Overflow:
  - stimulus: slot 1 holds 8'h66, d_out valid, ack=0; we=4'b0010 with 8'h77.
  - response: ovf=1, slot 1 still delivers 8'h66 later, 8'h77 never appears.
  - ovf stays 1 until reset.
- Rewrite on drain:
  - stimulus: only slot 3 used (8'h88), output empty; same cycle we[3]=1 with 8'h99.
  - response: d_out=8'h88 valid, used_pos=4'b1000 holding 8'h99, ovf=0.
  - next load: d_out=8'h99.
- Back-pressure:
  - stimulus: fill all 4 slots, hold ack=0 for 5 cycles.
  - response: d_out stable at the first word, used_pos=4'b1110, no data lost.
  - then: ack held high; the remaining 3 words arrive on 3 consecutive cycles.
